// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive sequencer.
// Holds the FSM state encoding, shift register width, the received-character
// payload struct and the frame-length helper.
package uart_rx_ctrl_pkg;

  localparam int unsigned SHIFT_W = 10;
  localparam int unsigned BCNT_W  = 4;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result of one completed frame as loaded into the output registers.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } rx_result_t;

  // Frame bits after the start bit: data bits + optional parity + stop.
  function automatic logic [BCNT_W-1:0] nbits(input logic eight, input logic pen);
    return BCNT_W'(8) + BCNT_W'(eight) + BCNT_W'(pen);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Processor-side read interface of the UART receiver.
//   rd_strobe : one-cycle read acknowledge from the register interface
//   rx_data   : received character
//   rxrdy     : character available
//   perr/ferr : parity / framing error of the last frame
//   ovf       : a frame completed while the previous character was unread
// The receiver uses the slave modport; the register interface uses master.
interface uart_rx_ctrl_if;
  import uart_rx_ctrl_pkg::*;

  logic              rd_strobe;
  logic [DATA_W-1:0] rx_data;
  logic              rxrdy;
  logic              perr;
  logic              ferr;
  logic              ovf;

  modport master (
    output rd_strobe,
    input  rx_data, rxrdy, perr, ferr, ovf
  );

  modport slave (
    input  rd_strobe,
    output rx_data, rxrdy, perr, ferr, ovf
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter shared by the UART receive and transmit sequencers.
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (restarts the bit period)
//   i_half     : 1 = time half a bit (baud_k>>1), 0 = a full bit (baud_k)
//   i_baud_k   : clocks per bit time
//   o_btu_c    : combinational bit-time-up pulse, count == target-1
module uart_rx_bit_timer #(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_half,
  input  logic [BAUD_W-1:0] i_baud_k,
  output logic              o_btu_c
);

  logic [BAUD_W-1:0] r_cnt;
  logic [BAUD_W-1:0] w_target;

  // ">=" rather than "==" so a target shrinking mid-count still terminates.
  always_comb begin
    w_target = i_half ? (i_baud_k >> 1) : i_baud_k;
    o_btu_c  = (r_cnt >= (w_target - BAUD_W'(1)));
  end

  // Counter wraps on btu so consecutive full-bit periods stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr || o_btu_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BAUD_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit detection, mid-bit sampling, parity and
// stop-bit checking, and a ready/acknowledge handshake for the received byte.
//   clk, reset : clock, asynchronous active-high reset
//   i_rx       : raw serial input (idle high), synchronised internally
//   i_baud_k   : clocks per bit time, stable during a frame
//   i_eight    : 1 = 8 data bits, 0 = 7 data bits
//   i_pen      : parity enable
//   i_ohel     : parity sense, 0 = even, 1 = odd
//   bus        : slave side of the processor read interface
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rx,
  input  logic [BAUD_W-1:0] i_baud_k,
  input  logic              i_eight,
  input  logic              i_pen,
  input  logic              i_ohel,
  uart_rx_ctrl_if.slave     bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic [BCNT_W-1:0]   r_bitcnt;
  logic [BCNT_W-1:0]   w_bitcnt_nxt;
  logic [SHIFT_W-1:0]  r_shift;
  logic [SHIFT_W-1:0]  w_shift_nxt;
  logic                w_load;
  logic                w_btu;
  logic                w_half;
  logic                w_clr;
  logic [BCNT_W-1:0]   w_nbits;
  logic [SHIFT_W-1:0]  w_aligned;
  logic                w_pbit;
  rx_result_t          w_res;

  logic [DATA_W-1:0]   r_rx_data;
  logic                r_rxrdy;
  logic                r_perr;
  logic                r_ferr;
  logic                r_ovf;

  assign w_nbits = nbits(i_eight, i_pen);
  assign w_half  = (r_state == ST_START);

  // Timer restarts on every state change; held cleared while idle.
  assign w_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE);

  uart_rx_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .i_half   (w_half),
    .i_baud_k (i_baud_k),
    .o_btu_c  (w_btu)
  );

  // Two-flop synchroniser; r_s2 is the rx_s used by all decisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
    end
  end

  // State, bit counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_load       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_bitcnt_nxt = '0;
        if (!r_s2) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_btu) begin
          w_state_nxt = r_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_btu) begin
          w_shift_nxt  = {r_s2, r_shift[SHIFT_W-1:1]};
          w_bitcnt_nxt = r_bitcnt + BCNT_W'(1);
          // ">=" keeps the frame bounded if eight/pen change mid-frame.
          if (r_bitcnt >= (w_nbits - BCNT_W'(1))) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_load       = 1'b1;
        w_bitcnt_nxt = '0;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame bits entered at the MSB; shift down so bit 0 is the first data bit.
  always_comb begin
    w_aligned      = r_shift >> (BCNT_W'(SHIFT_W) - w_nbits);
    w_pbit         = i_eight ? w_aligned[8] : w_aligned[7];
    w_res.data     = {i_eight & w_aligned[7], w_aligned[6:0]};
    w_res.perr     = i_pen & ((^w_res.data ^ w_pbit) != i_ohel);
    w_res.ferr     = ~w_aligned[w_nbits - BCNT_W'(1)];
  end

  // Output registers; a completed frame takes priority over a read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data <= '0;
      r_rxrdy   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_load) begin
      r_rx_data <= w_res.data;
      r_perr    <= w_res.perr;
      r_ferr    <= w_res.ferr;
      // A simultaneous read consumed the old character, so no overflow.
      r_ovf     <= r_rxrdy & ~bus.rd_strobe;
      r_rxrdy   <= 1'b1;
    end else if (bus.rd_strobe) begin
      r_rxrdy   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovf     <= 1'b0;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rxrdy   = r_rxrdy;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;
  assign bus.ovf     = r_ovf;

endmodule
